// File: rtl/proc_mailbox_pkg.sv
// Shared types and constants for the processor mailbox: register map,
// CONTROL bit positions and the STATUS word layout.
package proc_mailbox_pkg;

  localparam int unsigned MBOX_DATA_W = 32;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_RSVD    = 2'd3
  } mbox_reg_e;

  localparam int unsigned CTRL_FLUSH_RX   = 0;
  localparam int unsigned CTRL_FLUSH_TX   = 1;
  localparam int unsigned CTRL_CLR_STICKY = 2;
  localparam int unsigned CTRL_IRQ_EN     = 8;

  typedef struct packed {
    logic [11:0] rsvd;
    logic        be_err;
    logic        underflow;
    logic        tx_full;
    logic        rx_empty;
    logic [7:0]  tx_count;
    logic [7:0]  rx_count;
  } mbox_status_t;

  // CONTROL readback: only irq_en is visible.
  function automatic logic [MBOX_DATA_W-1:0] ctrl_readback(input logic irq_en);
    return MBOX_DATA_W'(irq_en) << CTRL_IRQ_EN;
  endfunction

endpackage

// File: rtl/proc_mailbox_if.sv
// Avalon-MM single-beat slave bus between the processor bridge and the mailbox.
interface proc_mailbox_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] s_address;
  logic              s_read;
  logic              s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_burstcount;
  logic              s_debugaccess;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic              s_waitrequest;

  modport master (
    output s_address, s_read, s_write, s_writedata, s_byteenable,
           s_burstcount, s_debugaccess,
    input  s_readdata, s_readdatavalid, s_waitrequest
  );

  modport slave (
    input  s_address, s_read, s_write, s_writedata, s_byteenable,
           s_burstcount, s_debugaccess,
    output s_readdata, s_readdatavalid, s_waitrequest
  );
endinterface

// File: rtl/proc_mailbox_fifo.sv
// First-word-fall-through register-array FIFO with occupancy count and
// synchronous flush; flush overrides any push/pop in the same cycle.
module mbox_sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_pop,
  output logic [DATA_W-1:0]      o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A push at full is only taken when a pop frees the head slot this cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/proc_mailbox.sv
// Inter-core mailbox: Avalon-MM slave with a TX message FIFO drained by a
// valid/ready source and an RX message FIFO filled by a valid/ready sink.
module proc_mailbox
  import proc_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  proc_mailbox_if.slave     s,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              irq
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] w_tx_head, w_rx_head, w_rdata;
  logic [CW-1:0]     w_tx_count, w_rx_count;
  logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic              w_in_range, w_is_data, w_be_ok;
  logic              w_wr_acc, w_rd_acc, w_data_wr, w_data_rd, w_ctrl_wr;
  logic              w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic              w_flush_tx, w_flush_rx, w_clr_sticky;
  logic              w_unused_ok;
  mbox_reg_e         w_reg;
  mbox_status_t      w_status;

  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid, r_irq_en, r_underflow, r_be_err, r_irq;

  assign w_reg      = mbox_reg_e'(s.s_address[3:2]);
  assign w_in_range = (s.s_address[ADDR_W-1:4] == '0);
  assign w_is_data  = w_in_range & (w_reg == REG_DATA);
  assign w_be_ok    = (s.s_byteenable == 4'hF);
  assign w_tx_pop   = ~w_tx_empty & tx_ready;

  // Only a DATA write into a full TX FIFO with no drain this cycle stalls.
  assign s.s_waitrequest = s.s_write & w_is_data & w_tx_full & ~w_tx_pop;

  // Write wins over a simultaneous read; the read is silently dropped.
  assign w_wr_acc     = s.s_write & ~s.s_waitrequest;
  assign w_rd_acc     = s.s_read & ~s.s_write;
  assign w_data_wr    = w_wr_acc & w_is_data;
  assign w_data_rd    = w_rd_acc & w_is_data;
  assign w_ctrl_wr    = w_wr_acc & w_in_range & (w_reg == REG_CONTROL);
  assign w_tx_push    = w_data_wr & w_be_ok;
  assign w_rx_pop     = w_data_rd & ~w_rx_empty;
  assign w_rx_push    = rx_valid & rx_ready;
  assign w_flush_rx   = w_ctrl_wr & s.s_writedata[CTRL_FLUSH_RX];
  assign w_flush_tx   = w_ctrl_wr & s.s_writedata[CTRL_FLUSH_TX];
  assign w_clr_sticky = w_ctrl_wr & s.s_writedata[CTRL_CLR_STICKY];

  assign tx_data  = w_tx_head;
  assign tx_valid = ~w_tx_empty;
  assign rx_ready = ~w_rx_full;
  assign irq      = r_irq;

  assign s.s_readdata      = r_rdata;
  assign s.s_readdatavalid = r_rvalid & ~reset_reset;

  assign w_unused_ok = ^{s.s_burstcount, s.s_debugaccess, s.s_address[1:0]};

  mbox_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .i_flush (w_flush_tx),
    .i_push  (w_tx_push),
    .i_data  (s.s_writedata),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_count (w_tx_count),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  mbox_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .i_flush (w_flush_rx),
    .i_push  (w_rx_push),
    .i_data  (rx_data),
    .i_pop   (w_rx_pop),
    .o_head  (w_rx_head),
    .o_count (w_rx_count),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_comb begin
    w_status           = '0;
    w_status.rx_count  = 8'(w_rx_count);
    w_status.tx_count  = 8'(w_tx_count);
    w_status.rx_empty  = w_rx_empty;
    w_status.tx_full   = w_tx_full;
    w_status.underflow = r_underflow;
    w_status.be_err    = r_be_err;
  end

  // Read mux; an empty-RX DATA read and all unmapped offsets return zero.
  always_comb begin
    w_rdata = '0;
    if (w_in_range) begin
      case (w_reg)
        REG_DATA:    if (!w_rx_empty) w_rdata = w_rx_head;
        REG_STATUS:  w_rdata = DATA_W'(w_status);
        REG_CONTROL: w_rdata = DATA_W'(ctrl_readback(r_irq_en));
        default:     w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_underflow <= 1'b0;
      r_be_err    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc)  r_rdata  <= w_rdata;
      if (w_ctrl_wr) r_irq_en <= s.s_writedata[CTRL_IRQ_EN];
      if (w_clr_sticky) begin
        r_underflow <= 1'b0;
        r_be_err    <= 1'b0;
      end else begin
        if (w_data_rd && w_rx_empty) r_underflow <= 1'b1;
        if (w_data_wr && !w_be_ok)   r_be_err    <= 1'b1;
      end
      r_irq <= r_irq_en & ~w_rx_empty;
    end
  end

endmodule

// File: tb/tb_proc_mailbox.sv
// Directed self-checking bench for proc_mailbox (DEPTH=16).
module tb_proc_mailbox;

  localparam logic [9:0] A_DATA = 10'h000;
  localparam logic [9:0] A_STAT = 10'h004;
  localparam logic [9:0] A_CTRL = 10'h008;
  localparam logic [9:0] A_OOR  = 10'h010;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
  int          checks = 0;
  int          errors = 0;
  logic        rv;
  logic [31:0] rd;

  always #5 clk = ~clk;

  proc_mailbox_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  proc_mailbox #(.DEPTH(16), .ADDR_W(10), .DATA_W(32)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .s           (bus),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .irq         (irq)
  );

  task automatic bus_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    @(negedge clk);
    bus.s_address = a; bus.s_writedata = d; bus.s_byteenable = be; bus.s_write = 1'b1;
    n = 0;
    #1;
    while (bus.s_waitrequest && n < 50) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL bus_wr_timeout addr=%h waitrequest stuck for %0d cycles", a, n);
    end
    @(posedge clk); #1;
    bus.s_write = 1'b0; bus.s_byteenable = 4'hF;
  endtask

  task automatic bus_rd(input logic [9:0] a, output logic v, output logic [31:0] d);
    @(negedge clk);
    bus.s_address = a; bus.s_read = 1'b1;
    @(posedge clk); #1;
    bus.s_read = 1'b0;
    @(negedge clk);
    v = bus.s_readdatavalid; d = bus.s_readdata;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.s_readdatavalid !== 1'b0 || bus.s_waitrequest !== 1'b0 || rx_ready !== 1'b1) begin
      errors++; $display("FAIL reset_bus rvalid=%b wait=%b rx_ready=%b need 0 0 1", bus.s_readdatavalid, bus.s_waitrequest, rx_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_out tx_valid=%b irq=%b need 0 0", tx_valid, irq);
    end
    bus_rd(A_STAT, rv, rd);
    checks++; if (rv !== 1'b1 || rd !== 32'h0001_0000) begin
      errors++; $display("FAIL reset_status valid=%b got %h need 00010000", rv, rd);
    end
    bus_rd(A_CTRL, rv, rd);
    checks++; if (rd !== 32'h0) begin
      errors++; $display("FAIL reset_control got %h need 00000000", rd);
    end
  endtask

  task automatic test_tx_stream();
    logic [31:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = 32'hA5A5_0001 + 32'(i);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++; if (tx_valid !== 1'b0) begin
          errors++; $display("FAIL tx_pre_valid got %b need 0", tx_valid);
        end
      end else begin
        checks++; if (tx_valid !== 1'b1 || tx_data !== w[i-1]) begin
          errors++; $display("FAIL tx_order%0d valid=%b got %h need %h", i - 1, tx_valid, tx_data, w[i-1]);
        end
      end
      bus.s_address = A_DATA; bus.s_writedata = w[i]; bus.s_write = 1'b1;
    end
    @(negedge clk);
    bus.s_write = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_data !== w[2]) begin
      errors++; $display("FAIL tx_order2 valid=%b got %h need %h", tx_valid, tx_data, w[2]);
    end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL tx_drained valid=%b need 0", tx_valid);
    end
    tx_ready = 1'b0;
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd[15:8] !== 8'h00) begin
      errors++; $display("FAIL tx_count_zero got %h need 00", rd[15:8]);
    end
  endtask

  task automatic test_tx_full();
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus_wr(A_DATA, 32'hB000_0000 + 32'(i), 4'hF);
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0003_1000) begin
      errors++; $display("FAIL full_status got %h need 00031000", rd);
    end
    @(negedge clk);
    bus.s_address = A_DATA; bus.s_writedata = 32'hB000_0010; bus.s_write = 1'b1;
    #1;
    checks++; if (bus.s_waitrequest !== 1'b1) begin
      errors++; $display("FAIL full_wait got %b need 1", bus.s_waitrequest);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.s_waitrequest !== 1'b1) begin
      errors++; $display("FAIL full_wait_hold got %b need 1", bus.s_waitrequest);
    end
    tx_ready = 1'b1;
    #1;
    checks++; if (bus.s_waitrequest !== 1'b0 || tx_data !== 32'hB000_0000) begin
      errors++; $display("FAIL full_release wait=%b head=%h need 0 b0000000", bus.s_waitrequest, tx_data);
    end
    @(posedge clk); #1;
    bus.s_write = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    checks++; if (tx_data !== 32'hB000_0001) begin
      errors++; $display("FAIL full_head got %h need b0000001", tx_data);
    end
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0003_1000) begin
      errors++; $display("FAIL full_pushpop_status got %h need 00031000", rd);
    end
    bus_wr(A_CTRL, 32'h2, 4'hF);
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0001_0000 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL tx_flush status=%h tx_valid=%b need 00010000 0", rd, tx_valid);
    end
  endtask

  task automatic test_rx_irq();
    bus_wr(A_CTRL, 32'h100, 4'hF);
    bus_rd(A_CTRL, rv, rd);
    checks++; if (rv !== 1'b1 || rd !== 32'h0000_0100) begin
      errors++; $display("FAIL irq_en_readback valid=%b got %h need 00000100", rv, rd);
    end
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 32'h1234_5678;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_early got %b need 0", irq);
    end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_rise got %b need 1", irq);
    end
    bus_rd(A_DATA, rv, rd);
    checks++; if (rv !== 1'b1 || rd !== 32'h1234_5678 || irq !== 1'b1) begin
      errors++; $display("FAIL rx_read valid=%b data=%h irq=%b need 1 12345678 1", rv, rd, irq);
    end
    @(negedge clk);
    checks++; if (bus.s_readdatavalid !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL rx_read_after valid=%b irq=%b need 0 0", bus.s_readdatavalid, irq);
    end
  endtask

  task automatic test_underflow();
    bus_rd(A_DATA, rv, rd);
    checks++; if (rv !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL underflow_read valid=%b data=%h need 1 00000000", rv, rd);
    end
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0005_0000) begin
      errors++; $display("FAIL underflow_status got %h need 00050000", rd);
    end
    bus_wr(A_CTRL, 32'h4, 4'hF);
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0001_0000) begin
      errors++; $display("FAIL underflow_clear got %h need 00010000", rd);
    end
  endtask

  task automatic test_be_err();
    tx_ready = 1'b0;
    bus_wr(A_DATA, 32'hDEAD_BEEF, 4'h3);
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL be_discard tx_valid=%b need 0", tx_valid);
    end
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0009_0000) begin
      errors++; $display("FAIL be_status got %h need 00090000", rd);
    end
    bus_wr(A_DATA, 32'hC0DE_0001, 4'hF);
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0009_0100) begin
      errors++; $display("FAIL be_push_status got %h need 00090100", rd);
    end
    @(negedge clk);
    tx_ready = 1'b1;
    bus.s_address = A_CTRL; bus.s_writedata = 32'h2; bus.s_write = 1'b1;
    @(posedge clk); #1;
    bus.s_write = 1'b0; tx_ready = 1'b0;
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0009_0000 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL flush_pop status=%h tx_valid=%b need 00090000 0", rd, tx_valid);
    end
    bus_wr(A_CTRL, 32'h4, 4'hF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = 32'h5A00_0000 + 32'(i);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = w[0];
    @(negedge clk);
    rx_data = w[1]; bus.s_address = A_DATA; bus.s_read = 1'b1;
    @(negedge clk);
    checks++; if (bus.s_readdatavalid !== 1'b1 || bus.s_readdata !== w[0]) begin
      errors++; $display("FAIL b2b_rd0 valid=%b got %h need %h", bus.s_readdatavalid, bus.s_readdata, w[0]);
    end
    rx_data = w[2];
    @(negedge clk);
    checks++; if (bus.s_readdatavalid !== 1'b1 || bus.s_readdata !== w[1]) begin
      errors++; $display("FAIL b2b_rd1 valid=%b got %h need %h", bus.s_readdatavalid, bus.s_readdata, w[1]);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.s_readdatavalid !== 1'b1 || bus.s_readdata !== w[2]) begin
      errors++; $display("FAIL b2b_rd2 valid=%b got %h need %h", bus.s_readdatavalid, bus.s_readdata, w[2]);
    end
    bus.s_read = 1'b0;
    @(negedge clk);
    checks++; if (bus.s_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL b2b_single_strobe valid=%b need 0", bus.s_readdatavalid);
    end
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0001_0000) begin
      errors++; $display("FAIL b2b_status got %h need 00010000", rd);
    end
    tx_ready = 1'b0;
    @(negedge clk);
    bus.s_address = A_DATA; bus.s_writedata = 32'h7777_0001; bus.s_read = 1'b1; bus.s_write = 1'b1;
    @(posedge clk); #1;
    bus.s_read = 1'b0; bus.s_write = 1'b0;
    @(negedge clk);
    checks++; if (bus.s_readdatavalid !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 32'h7777_0001) begin
      errors++; $display("FAIL rdwr_collision rvalid=%b tx_valid=%b tx_data=%h need 0 1 77770001", bus.s_readdatavalid, tx_valid, tx_data);
    end
    bus_wr(A_OOR, 32'h0000_0003, 4'hF);
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0001_0100) begin
      errors++; $display("FAIL oor_write status=%h need 00010100", rd);
    end
    bus_wr(A_CTRL, 32'h2, 4'hF);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 32'hABCD_0000;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    bus_rd(A_OOR, rv, rd);
    checks++; if (rv !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL oor_read valid=%b data=%h need 1 00000000", rv, rd);
    end
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0000_0001) begin
      errors++; $display("FAIL oor_status got %h need 00000001", rd);
    end
    bus_wr(A_CTRL, 32'h1, 4'hF);
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0001_0000) begin
      errors++; $display("FAIL rx_flush got %h need 00010000", rd);
    end
  endtask

  task automatic test_reset_mid();
    bus_wr(A_CTRL, 32'h100, 4'hF);
    tx_ready = 1'b0;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 32'h6000_0001;
    @(negedge clk);
    rx_data = 32'h6000_0002;
    @(negedge clk);
    rx_valid = 1'b0;
    bus_wr(A_DATA, 32'h5555_0001, 4'hF);
    @(negedge clk);
    checks++; if (irq !== 1'b1 || tx_valid !== 1'b1) begin
      errors++; $display("FAIL mid_setup irq=%b tx_valid=%b need 1 1", irq, tx_valid);
    end
    @(negedge clk);
    bus.s_address = A_DATA; bus.s_read = 1'b1;
    @(posedge clk); #1;
    bus.s_read = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.s_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL mid_rvalid_in_reset got %b need 0", bus.s_readdatavalid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.s_readdatavalid !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL mid_after rvalid=%b tx_valid=%b rx_ready=%b irq=%b need 0 0 1 0", bus.s_readdatavalid, tx_valid, rx_ready, irq);
    end
    bus_rd(A_STAT, rv, rd);
    checks++; if (rd !== 32'h0001_0000) begin
      errors++; $display("FAIL mid_status got %h need 00010000", rd);
    end
    bus_rd(A_CTRL, rv, rd);
    checks++; if (rd !== 32'h0) begin
      errors++; $display("FAIL mid_control got %h need 00000000", rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    bus.s_address = '0; bus.s_read = 1'b0; bus.s_write = 1'b0; bus.s_writedata = '0;
    bus.s_byteenable = 4'hF; bus.s_burstcount = 1'b1; bus.s_debugaccess = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_tx_stream();
    test_tx_full();
    test_rx_irq();
    test_underflow();
    test_be_err();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_mailbox.md
# proc_mailbox

Avalon-MM slave that terminates a processor's `out_bridge` master port (10-bit byte address, 32-bit data, single-beat) and exposes two 32-bit message FIFOs. The TX FIFO is filled by processor writes and drained by a valid/ready stream toward the interconnect or another processor. The RX FIFO is filled by a valid/ready stream and drained by processor reads. It is the processor's inter-core mailbox, directly downstream of the processor bridge.

## Interface
Parameters:
- `DEPTH`, 16: entries per FIFO. Power of two, 2..128.
- `ADDR_W`, 10: slave byte-address width.
- `DATA_W`, 32: data width. Fixed at 32.

Ports:
- `clk_clk` in 1: single clock; all logic rises on it.
- `reset_reset` in 1: synchronous, active-high reset.
- `s_address` in 10: byte address. Bits [3:2] select the register.
- `s_read` in 1: read request.
- `s_write` in 1: write request.
- `s_writedata` in 32: write data.
- `s_byteenable` in 4: byte lanes.
- `s_burstcount` in 1: always 1; ignored.
- `s_debugaccess` in 1: ignored.
- `s_readdata` out 32: read data, valid with `s_readdatavalid`.
- `s_readdatavalid` out 1: read response strobe.
- `s_waitrequest` out 1: back-pressure on the current request.
- `tx_data` out 32 / `tx_valid` out 1 / `tx_ready` in 1: TX stream source.
- `rx_data` in 32 / `rx_valid` in 1 / `rx_ready` out 1: RX stream sink.
- `irq` out 1: RX-not-empty interrupt, level, registered.

## Operation
- Register map (word offsets, byte addresses):
  - 0x000 DATA: a write pushes to TX; a read pops from RX.
  - 0x004 STATUS: read-only.
  - 0x008 CONTROL.
  - 0x00C reserved.
  - Addresses ≥ 0x010 read 0; writes to them are ignored.
- STATUS bits:
  - [7:0] rx_count, [15:8] tx_count.
  - [16] rx_empty, [17] tx_full.
  - [18] underflow: sticky; set by a DATA read while RX is empty.
  - [19] be_err: sticky; set by a DATA write with `s_byteenable` ≠ 4'hF. That write is discarded.
  - [31:20] read as 0.
- CONTROL write bits (self-clearing): bit0 flush RX, bit1 flush TX, bit2 clear sticky bits.
- CONTROL bit8 is irq_en, read/write. A CONTROL read returns irq_en at bit8 and 0 elsewhere.
- A DATA read while RX is empty returns 0x0000_0000, pops nothing, and sets underflow.
- Both FIFOs are first-word-fall-through:
  - `tx_data` = TX head; `tx_valid` = !tx_empty.
  - `rx_ready` = !rx_full. This is computed from the count only, so there is no same-cycle pop-to-push pass-through.
- A stream transfer occurs when valid & ready are both high on a rising edge.
- `irq` is registered: `irq` <= irq_en & !rx_empty.
- Simultaneous events:
  - Flush and push/pop on the same FIFO in the same cycle: flush wins and the count becomes 0.
  - Push and pop on the same FIFO in the same cycle: the count is unchanged. This is legal at full for TX and at empty for neither (an empty FIFO has nothing to pop).
  - `s_read` and `s_write` asserted together: protocol violation. The write is processed and the read is dropped.
- Reset values:
  - `s_readdata`=0, `s_readdatavalid`=0, `s_waitrequest`=0.
  - `tx_valid`=0, `rx_ready`=1, `irq`=0.
  - Both FIFOs empty; irq_en=0; sticky bits 0.
- Reset mid-operation: FIFO contents are discarded, and any pending read response is cancelled (no `s_readdatavalid` after reset).

## Timing
- Read latency is fixed at 1. A read accepted in cycle N (`s_read` & !`s_waitrequest`) gives `s_readdatavalid`=1 with data in cycle N+1, for exactly one cycle.
- `s_waitrequest` is combinational:
  - It is 1 only for a DATA write while tx_full & !(tx_valid & tx_ready).
  - It is held until space exists. The master keeps its request stable meanwhile.
  - Reads are never stalled.
- The RX pop takes effect at the edge that accepts the read. STATUS read in the next accepted cycle reflects the decremented count.
- An RX stream push in cycle N is visible to a DATA read accepted in cycle N+1. A DATA read in cycle N itself sees the pre-push state.
- `tx_valid` rises in the cycle after the first TX push.
- Throughput: one bus transaction per cycle and one transfer per cycle on each stream, all concurrent.

## Structure
- Package `proc_mailbox_pkg` holds:
  - register offsets (REG_DATA, REG_STATUS, REG_CONTROL);
  - STATUS/CONTROL bit positions;
  - a `mbox_status_t` packed struct.
- Sub-module `mbox_sync_fifo` (parameters `DEPTH`, `DATA_W`) provides:
  - a FWFT register-array FIFO;
  - a count output, a synchronous flush, and full/empty flags.
- It is instantiated twice (TX, RX). The top level holds the bus decode, sticky bits, irq_en, the irq register and the read-response register.

## Test plan
1. Write 0xA5A5_0001..0xA5A5_0003 to 0x000 with `tx_ready`=1 → `tx_data` emits the three words in order, the first one cycle after the first write. STATUS tx_count returns to 0.
2. Hold `tx_ready`=0 and write DEPTH+1 words → the 17th write (DEPTH=16) sees `s_waitrequest`=1 until one `tx_ready` pulse. STATUS[17]=1 while full.
3. Push 0x1234_5678 on RX with irq_en=1 → `irq`=1 two cycles after the push. A DATA read returns 0x1234_5678 with latency 1. `irq` falls after the pop.
4. Read DATA with RX empty → readdata 0, STATUS[18]=1. CONTROL write 0x4 → STATUS[18]=0.
5. DATA write with byteenable 4'h3 → TX unchanged, STATUS[19]=1. A same-cycle TX flush plus `tx_ready` pop → tx_count 0.
6. Assert `reset_reset` the cycle after a DATA read is accepted → no `s_readdatavalid`, both FIFOs empty, `rx_ready`=1, `irq`=0.
